// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE absorb path: FSM state encoding,
// rate sizes in 64-bit words and the padding bytes.
package shake_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PAD_FIRST = 3'd2,
    PAD_ZERO  = 3'd3,
    HANDOFF   = 3'd4
  } state_t;

  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;

  localparam logic [7:0] SHAKE_DS = 8'h1F;
  localparam logic [7:0] PAD_END  = 8'h80;

endpackage

// File: rtl/shake_pad_word.sv
// Combinational word formatter: masks the final message word and inserts the
// SHAKE domain suffix and the closing 0x80 bit of the pad10*1 rule.
module shake_pad_word
  import shake_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        n_bytes,
  input  logic              is_last_msg,
  input  logic              is_pad_first,
  input  logic              last_w,
  output logic [DATA_W-1:0] word
);

  // Select between pass-through, pad-only word and masked final message word
  always_comb begin
    word = data;
    if (is_pad_first) begin
      word = '0;
      word[7:0] = SHAKE_DS;
      if (last_w) begin
        word[DATA_W-1 -: 8] = PAD_END;
      end else begin
        word[DATA_W-1 -: 8] = 8'h00;
      end
    end else if (is_last_msg && (n_bytes != 3'd0)) begin
      // Bytes below n keep message data; byte n carries the suffix; the rest are zero
      for (int k = 0; k < DATA_W / 8; k++) begin
        if (k < int'(n_bytes)) begin
          word[8*k +: 8] = data[8*k +: 8];
        end else if (k == int'(n_bytes)) begin
          word[8*k +: 8] = SHAKE_DS;
        end else begin
          word[8*k +: 8] = 8'h00;
        end
      end
      if (last_w) begin
        word[DATA_W-1 -: 8] = word[DATA_W-1 -: 8] | PAD_END;
      end else begin
        word[DATA_W-1 -: 8] = word[DATA_W-1 -: 8];
      end
    end else begin
      word = data;
    end
  end

endmodule

// File: rtl/absorb_fsm.sv
// Input-side controller of the SHAKE core: accepts message words, writes them
// padded into the rate buffer and hands full blocks to the permutation.
module absorb_fsm
  import shake_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              mode_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  input  logic [2:0]        last_bytes_in,
  output logic              buf_we,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] buf_data,
  output logic              block_valid,
  input  logic              block_ready,
  output logic              block_last,
  output logic              absorb_done
);

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               mode_r;
  logic               pad_pending_r;
  logic               last_flag_r;

  logic [IDX_W-1:0]   rate_m1_s;
  logic               last_w_s;
  logic               accept_s;
  logic [DATA_W-1:0]  pad_in_s;
  logic [DATA_W-1:0]  pad_word_s;

  assign rate_m1_s = mode_r ? IDX_W'(RATE256_WORDS - 1) : IDX_W'(RATE128_WORDS - 1);
  assign last_w_s  = (idx_r == rate_m1_s);
  assign accept_s  = (state_r == LOAD) && valid_in;

  // Padding-only words feed a zero word, carrying the closing bit on the last lane
  always_comb begin
    pad_in_s = data_in;
    if (state_r == PAD_ZERO) begin
      if (last_w_s) begin
        pad_in_s = {PAD_END, {(DATA_W-8){1'b0}}};
      end else begin
        pad_in_s = '0;
      end
    end else begin
      pad_in_s = data_in;
    end
  end

  shake_pad_word #(
    .DATA_W (DATA_W)
  ) u_pad (
    .data         (pad_in_s),
    .n_bytes      (last_bytes_in),
    .is_last_msg  (accept_s && last_in),
    .is_pad_first (state_r == PAD_FIRST),
    .last_w       (last_w_s),
    .word         (pad_word_s)
  );

  // Outputs decode directly from the state/flag registers; buffer write is zero-latency
  always_comb begin
    ready_out   = (state_r == LOAD);
    buf_we      = accept_s || (state_r == PAD_FIRST) || (state_r == PAD_ZERO);
    buf_idx     = buf_we ? idx_r : '0;
    buf_data    = buf_we ? pad_word_s : '0;
    block_valid = (state_r == HANDOFF);
    block_last  = (state_r == HANDOFF) && last_flag_r;
    absorb_done = (state_r == HANDOFF) && last_flag_r && block_ready;
  end

  // Absorb sequencing: word index, mode, pending-pad and final-block flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      mode_r        <= 1'b0;
      pad_pending_r <= 1'b0;
      last_flag_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_in) begin
            mode_r        <= mode_in;
            idx_r         <= '0;
            pad_pending_r <= 1'b0;
            last_flag_r   <= 1'b0;
            state_r       <= LOAD;
          end
        end
        LOAD: begin
          if (valid_in) begin
            if (!last_in) begin
              if (last_w_s) begin
                last_flag_r <= 1'b0;
                state_r     <= HANDOFF;
              end else begin
                idx_r <= idx_r + IDX_W'(1);
              end
            end else if (last_bytes_in != 3'd0) begin
              if (last_w_s) begin
                last_flag_r <= 1'b1;
                state_r     <= HANDOFF;
              end else begin
                idx_r   <= idx_r + IDX_W'(1);
                state_r <= PAD_ZERO;
              end
            end else begin
              // A full final word that closes the block pushes the suffix into a fresh block
              if (last_w_s) begin
                pad_pending_r <= 1'b1;
                last_flag_r   <= 1'b0;
                state_r       <= HANDOFF;
              end else begin
                idx_r   <= idx_r + IDX_W'(1);
                state_r <= PAD_FIRST;
              end
            end
          end
        end
        PAD_FIRST: begin
          if (last_w_s) begin
            last_flag_r <= 1'b1;
            state_r     <= HANDOFF;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            state_r <= PAD_ZERO;
          end
        end
        PAD_ZERO: begin
          if (last_w_s) begin
            last_flag_r <= 1'b1;
            state_r     <= HANDOFF;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        HANDOFF: begin
          if (block_ready) begin
            idx_r <= '0;
            if (last_flag_r) begin
              state_r <= IDLE;
            end else if (pad_pending_r) begin
              pad_pending_r <= 1'b0;
              state_r       <= PAD_FIRST;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_fsm.sv
// Randomised scoreboard bench for absorb_fsm: a byte-level SHAKE padder
// predicts every buffer write and block boundary.
module tb_absorb_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  logic        mode_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [63:0] data_in = 64'd0;
  logic        last_in = 1'b0;
  logic [2:0]  last_bytes_in = 3'd0;
  logic        buf_we;
  logic [4:0]  buf_idx;
  logic [63:0] buf_data;
  logic        block_valid;
  logic        block_ready = 1'b0;
  logic        block_last;
  logic        absorb_done;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_blk[$];
  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;
  bit  sb_en = 1'b1;
  bit  stall_req = 1'b0;
  int  br_prob = 60;

  absorb_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .mode_in       (mode_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_in       (data_in),
    .last_in       (last_in),
    .last_bytes_in (last_bytes_in),
    .buf_we        (buf_we),
    .buf_idx       (buf_idx),
    .buf_data      (buf_data),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_last    (block_last),
    .absorb_done   (absorb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference padder: message bytes, then 0x1F, zero fill to the rate, 0x80 on the final byte
  task automatic model(input bit mode, input logic [63:0] w[$], input int nb);
    logic [7:0]  q[$];
    logic [63:0] d;
    int rate_b, nbytes, nwords, rate;
    rate   = mode ? 17 : 21;
    rate_b = 8 * rate;
    for (int i = 0; i < w.size(); i++) begin
      nbytes = (i == w.size() - 1) ? ((nb == 0) ? 8 : nb) : 8;
      for (int k = 0; k < nbytes; k++) q.push_back(w[i][8*k +: 8]);
    end
    q.push_back(8'h1F);
    while ((q.size() % rate_b) != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    nwords = q.size() / 8;
    for (int j = 0; j < nwords; j++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = q[8*j + k];
      exp_wr.push_back('{idx: 5'(j % rate), data: d});
    end
    for (int b = 0; b < q.size() / rate_b; b++) exp_blk.push_back(b == (q.size() / rate_b) - 1);
  endtask

  // Monitor: pops expected writes and block boundaries as the DUT presents them
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (buf_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {59'd0, buf_idx, buf_data}, 128'd0);
          end else begin
            e = exp_wr.pop_front();
            chk("buf_write", {59'd0, buf_idx, buf_data}, {59'd0, e.idx, e.data});
          end
        end
        if (block_valid && block_ready) begin
          if (exp_blk.size() == 0) begin
            chk("unexpected_block", 128'(block_last), 128'd2);
          end else begin
            bit eb;
            eb = exp_blk.pop_front();
            chk("block_last", 128'(block_last), 128'(eb));
            chk("absorb_done_at_handoff", 128'(absorb_done), 128'(eb));
          end
        end else if (absorb_done) begin
          chk("absorb_done_stray", 128'(absorb_done), 128'd0);
        end
        if (absorb_done) done_cnt++;
      end
    end
  end

  // Block-ready driver: random acceptance, or a 10-cycle hold when a stall is requested
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_req && block_valid) begin
        stall_req   = 1'b0;
        block_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk("stall_block_valid", 128'(block_valid), 128'd1);
          chk("stall_ready_out", 128'(ready_out), 128'd0);
          chk("stall_no_write", 128'(buf_we), 128'd0);
          @(posedge clk); #1;
        end
        block_ready = 1'b1;
      end else begin
        block_ready = ($urandom_range(99) < br_prob);
      end
    end
  end

  task automatic run_msg(input bit mode, input logic [63:0] w[$], input int nb, input int vprob);
    bit accepted;
    int cyc;
    model(mode, w, nb);
    done_cnt = 0;
    @(posedge clk); #1;
    start_in = 1'b1;
    mode_in  = mode;
    @(posedge clk); #1;
    start_in = 1'b0;
    mode_in  = ~mode;
    for (int i = 0; i < w.size(); i++) begin
      data_in       = w[i];
      last_in       = (i == w.size() - 1);
      last_bytes_in = 3'(nb);
      accepted      = 1'b0;
      cyc           = 0;
      while (!accepted && cyc < 500) begin
        valid_in = ($urandom_range(99) < vprob);
        @(negedge clk);
        accepted = valid_in && ready_out;
        @(posedge clk); #1;
        cyc++;
      end
      if (!accepted) chk("word_accept_timeout", 128'(i), 128'hFFFF);
      valid_in = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("absorb_done_once", 128'(done_cnt), 128'd1);
    chk("writes_drained", 128'(exp_wr.size()), 128'd0);
    chk("blocks_drained", 128'(exp_blk.size()), 128'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_outputs"}, {ready_out, buf_we, buf_idx, buf_data, block_valid, block_last, absorb_done},
        75'd0);
  endtask

  initial begin
    logic [63:0] w[$];
    bit accepted;
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    // SHAKE128 single partial word
    w = {};
    w.push_back(64'h0000_0000_0000_00AB);
    run_msg(1'b0, w, 1, 100);

    // SHAKE256 17 full words: unpadded block then a pad-only block
    w = {};
    for (int i = 0; i < 17; i++) w.push_back({$urandom, $urandom});
    run_msg(1'b1, w, 0, 100);

    // SHAKE256 17 words, 7 bytes in the last: suffix and end bit share byte 7
    w = {};
    for (int i = 0; i < 17; i++) w.push_back({$urandom, $urandom});
    run_msg(1'b1, w, 7, 100);

    // 40-word SHAKE128 with toggling valid and a held-off first handoff
    w = {};
    for (int i = 0; i < 40; i++) w.push_back({$urandom, $urandom});
    stall_req = 1'b1;
    run_msg(1'b0, w, $urandom_range(7), 50);

    // Random messages across both modes and all final-word lengths
    for (int m = 0; m < 8; m++) begin
      w = {};
      for (int i = 0; i < int'($urandom_range(45, 1)); i++) w.push_back({$urandom, $urandom});
      run_msg(1'($urandom_range(1)), w, $urandom_range(7), 70);
    end

    // Reset while padding: drive a 1-word message, stop in PAD_ZERO, pulse reset
    sb_en = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b1;
    mode_in  = 1'b0;
    @(posedge clk); #1;
    start_in      = 1'b0;
    data_in       = 64'h1234_5678_9ABC_DEF0;
    last_in       = 1'b1;
    last_bytes_in = 3'd3;
    valid_in      = 1'b1;
    accepted      = 1'b0;
    cyc           = 0;
    while (!accepted && cyc < 50) begin
      @(negedge clk);
      accepted = ready_out;
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0;
    if (!accepted) chk("rst_test_accept_timeout", 128'd0, 128'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pad_zero_writing", {123'd0, buf_we, 4'd0}, {123'd0, 1'b1, 4'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    exp_wr.delete();
    exp_blk.delete();
    sb_en = 1'b1;

    // Clean message after the interrupted one
    w = {};
    for (int i = 0; i < 5; i++) w.push_back({$urandom, $urandom});
    run_msg(1'b1, w, 2, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
